reg_dump_unit: RTL and testbench

REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

---
 rtl/reg_dump_unit_if.sv | 24 ++
 rtl/reg_dump_unit.sv | 80 ++++++++
 tb/tb_reg_dump_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_unit_if.sv
// Dump-unit bus: start/busy/done control, register-file read port and the
// valid/ready output word stream.
interface reg_dump_unit_if;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_last;

    modport master (
        input  start, rf_data, out_ready,
        output busy, done, rf_addr, out_valid, out_data, out_index, out_last
    );

    modport slave (
        output start, rf_data, out_ready,
        input  busy, done, rf_addr, out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/reg_dump_unit.sv
// Walks register indices START_REG..END_REG, reading the async register file
// and streaming each word out over a valid/ready handshake.
module reg_dump_unit #(
    parameter int START_REG = 0,
    parameter int END_REG   = 31
) (
    input  logic            clk,
    input  logic            rst,
    reg_dump_unit_if.master bus
);

    localparam logic [4:0] START_IDX = 5'(START_REG);
    localparam logic [4:0] END_IDX   = 5'(END_REG);

    typedef enum logic [1:0] {IDLE, READ, SEND} state_t;

    state_t      r_state;
    logic [4:0]  r_idx;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic [4:0]  r_out_index;
    logic        r_out_last;
    logic        r_done;
    logic        w_at_end;

    assign w_at_end = (r_idx == END_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= START_IDX;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_idx   <= START_IDX;
                        r_state <= READ;
                    end
                end
                READ: begin
                    r_out_data  <= bus.rf_data;
                    r_out_index <= r_idx;
                    r_out_last  <= w_at_end;
                    r_out_valid <= 1'b1;
                    r_state     <= SEND;
                end
                SEND: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        // Increment only below END_IDX so index 31 never wraps to 0.
                        if (w_at_end) begin
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_idx   <= r_idx + 5'd1;
                            r_state <= READ;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = r_done;
    assign bus.rf_addr   = r_idx;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_index = r_out_index;
    assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Scoreboard bench: stimulus queues expected words, negedge monitors pop and
// compare on every accepted handshake of the two DUT configurations.
module tb_reg_dump_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_dump_unit_if dif();
    reg_dump_unit_if pif();

    reg_dump_unit #(.START_REG(0), .END_REG(31)) dut (.clk(clk), .rst(rst), .bus(dif));
    reg_dump_unit #(.START_REG(5), .END_REG(5))  dut5 (.clk(clk), .rst(rst), .bus(pif));

    logic [31:0] rf [32];
    assign dif.rf_data = rf[dif.rf_addr];
    assign pif.rf_data = rf[pif.rf_addr];

    typedef struct {
        logic [31:0] d;
        logic [4:0]  i;
        logic        l;
    } exp_t;

    exp_t q[$];
    exp_t q5[$];
    exp_t e;
    exp_t e5;
    int   n_cmp = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   done5_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && dif.out_valid && dif.out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_word_idx", 32'(dif.out_index), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("word_data", dif.out_data, e.d);
                chk("word_index", 32'(dif.out_index), 32'(e.i));
                chk("word_last", 32'(dif.out_last), 32'(e.l));
            end
        end
        if (!rst && dif.done) done_cnt++;
    end

    always @(negedge clk) begin
        if (!rst && pif.out_valid && pif.out_ready) begin
            if (q5.size() == 0) begin
                chk("p5_unexpected_word_idx", 32'(pif.out_index), 32'hFFFF_FFFF);
            end else begin
                e5 = q5.pop_front();
                chk("p5_word_data", pif.out_data, e5.d);
                chk("p5_word_index", 32'(pif.out_index), 32'(e5.i));
                chk("p5_word_last", 32'(pif.out_last), 32'(e5.l));
            end
        end
        if (!rst && pif.done) done5_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            exp_t x;
            x.d = 32'h1000_0000 + 32'(i);
            x.i = 5'(i);
            x.l = (i == 31);
            q.push_back(x);
        end
    endtask

    task automatic pulse_start();
        dif.start = 1'b1;
        tick();
        dif.start = 1'b0;
    endtask

    task automatic wait_word(input int idx);
        int n = 0;
        while (!(dif.out_valid && dif.out_index == 5'(idx)) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk("timeout_wait_word", 32'(n), 32'(idx));
    endtask

    task automatic wait_done();
        int n = 0;
        while (!dif.done && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk("timeout_wait_done", 32'(n), 32'd0);
    endtask

    initial begin
        int cnt;
        int dc0;
        exp_t x;

        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
        rst = 1'b1;
        dif.start = 1'b0; dif.out_ready = 1'b1;
        pif.start = 1'b0; pif.out_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_busy", 32'(dif.busy), 32'd0);
        chk("rst_valid", 32'(dif.out_valid), 32'd0);
        chk("rst_done", 32'(dif.done), 32'd0);
        chk("rst_rf_addr", 32'(dif.rf_addr), 32'd0);
        chk("rst_out_data", dif.out_data, 32'd0);
        chk("rst_out_index", 32'(dif.out_index), 32'd0);
        chk("rst_p5_rf_addr", 32'(pif.rf_addr), 32'd5);
        rst = 1'b0;
        tick();

        // Full dump with latency measurement
        push_range(0, 31);
        dif.start = 1'b1;
        tick();
        dif.start = 1'b0;
        cnt = 1;
        while (!dif.out_valid && cnt < 10) begin tick(); cnt++; end
        chk("lat_first_valid", 32'(cnt), 32'd2);
        chk("busy_during_dump", 32'(dif.busy), 32'd1);
        while (!dif.done && cnt < 300) begin tick(); cnt++; end
        chk("lat_start_to_done", 32'(cnt), 32'd65);
        chk("done_busy_low", 32'(dif.busy), 32'd0);
        tick();
        chk("done_one_cycle", 32'(dif.done), 32'd0);
        chk("full_q_empty", 32'(q.size()), 32'd0);

        // Backpressure on index 3
        push_range(0, 31);
        pulse_start();
        wait_word(3);
        dif.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", 32'(dif.out_valid), 32'd1);
            chk("bp_data", dif.out_data, 32'h1000_0003);
            chk("bp_index", 32'(dif.out_index), 32'd3);
        end
        dif.out_ready = 1'b1;
        wait_done();
        tick();
        chk("bp_q_empty", 32'(q.size()), 32'd0);

        // Start while busy is ignored
        dc0 = done_cnt;
        push_range(0, 31);
        pulse_start();
        wait_word(10);
        pulse_start();
        wait_done();
        repeat (4) tick();
        chk("busy_start_ignored", 32'(dif.busy), 32'd0);
        chk("busy_start_one_done", 32'(done_cnt - dc0), 32'd1);
        chk("busy_q_empty", 32'(q.size()), 32'd0);

        // Reset while SEND holds index 7
        push_range(0, 6);
        pulse_start();
        wait_word(7);
        dif.out_ready = 1'b0;
        dc0 = done_cnt;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", 32'(dif.out_valid), 32'd0);
        chk("abort_busy", 32'(dif.busy), 32'd0);
        chk("abort_done", 32'(dif.done), 32'd0);
        chk("abort_rf_addr", 32'(dif.rf_addr), 32'd0);
        dif.out_ready = 1'b1;
        repeat (3) tick();
        chk("abort_no_valid", 32'(dif.out_valid), 32'd0);
        chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
        chk("abort_q_empty", 32'(q.size()), 32'd0);
        push_range(0, 31);
        pulse_start();
        wait_done();
        tick();
        chk("restart_q_empty", 32'(q.size()), 32'd0);

        // Write to reg 12 at the negedge just before its READ edge
        push_range(0, 11);
        x.d = 32'hDEAD_BEEF; x.i = 5'd12; x.l = 1'b0;
        q.push_back(x);
        push_range(13, 31);
        pulse_start();
        wait_word(11);
        @(posedge clk);
        @(negedge clk);
        rf[12] = 32'hDEAD_BEEF;
        #1;
        wait_done();
        tick();
        chk("cw_q_empty", 32'(q.size()), 32'd0);
        rf[12] = 32'h1000_000C;

        // Single-register config, start held high: back-to-back dumps
        x.d = 32'h1000_0005; x.i = 5'd5; x.l = 1'b1;
        q5.push_back(x);
        q5.push_back(x);
        pif.start = 1'b1;
        cnt = 0;
        while (!pif.done && cnt < 50) begin tick(); cnt++; end
        chk("p5_lat_done", 32'(cnt), 32'd3);
        chk("p5_done_busy_low", 32'(pif.busy), 32'd0);
        tick();
        chk("p5_immediate_restart", 32'(pif.busy), 32'd1);
        chk("p5_rf_addr", 32'(pif.rf_addr), 32'd5);
        cnt = 0;
        while (!pif.done && cnt < 50) begin tick(); cnt++; end
        pif.start = 1'b0;
        repeat (4) tick();
        chk("p5_q_empty", 32'(q5.size()), 32'd0);
        chk("p5_idle_after", 32'(pif.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
